// File: rtl/mul_add_nat.sv
// mul_add_nat: combinational multiply-add m = x*y + c on natural operands.
// Ports:
//   x : N-bit multiplicand
//   y : M-bit multiplier digit
//   c : N-bit addend
//   m : N+M-bit result; (2^N-1)(2^M-1) + 2^N-1 < 2^(N+M), so it never overflows
module mul_add_nat #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic [N-1:0]   x,
    input  logic [M-1:0]   y,
    input  logic [N-1:0]   c,
    output logic [N+M-1:0] m
);
    assign m = (N+M)'(x) * (N+M)'(y) + (N+M)'(c);
endmodule

// File: rtl/mul_seq_nat.sv
// mul_seq_nat: sequential radix-4 multiplier, one 2-bit multiplier digit per clock.
// Ports:
//   clock  : system clock, rising edge
//   reset_ : asynchronous active-low reset
//   x, y   : N-bit natural operands, sampled when soc is seen in idle
//   soc    : start of conversion
//   eoc    : registered; 1 = idle or result valid, 0 = busy
//   p      : 2N-bit product {A,Q}
module mul_seq_nat #(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           soc,
    output logic           eoc,
    output logic [2*N-1:0] p
);
    localparam int STEPS = N / 2;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [1:0]    r_star;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_q;
    logic [N+1:0]  w_m;

    mul_add_nat #(.N(N), .M(2)) u_mac (
        .x (r_x),
        .y (r_q[1:0]),
        .c (r_a),
        .m (w_m)
    );

    assign p = {r_a, r_q};

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_star  <= S0;
            r_count <= '0;
            r_x     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            eoc     <= 1'b1;
        end else begin
            case (r_star)
                S0: if (soc) begin
                    r_x     <= x;
                    r_q     <= y;
                    r_a     <= '0;
                    r_count <= CW'(STEPS - 1);
                    eoc     <= 1'b0;
                    r_star  <= S1;
                end
                S1: begin
                    // low two bits of m retire into the top of Q as Q shifts right by a digit
                    r_a     <= w_m[N+1:2];
                    r_q     <= N'({w_m[1:0], r_q} >> 2);
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        eoc    <= 1'b1;
                        r_star <= S2;
                    end
                end
                S2: if (!soc) r_star <= S0;
                default: r_star <= S0;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_nat.sv
// tb_mul_seq_nat: table-driven and scoreboard checks for mul_seq_nat (N=8).
module tb_mul_seq_nat;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0]   x;
        logic [N-1:0]   y;
        logic [2*N-1:0] e;
    } vec_t;

    logic           clock = 1'b0;
    logic           reset_ = 1'b0;
    logic           soc = 1'b0;
    logic [N-1:0]   x = '0;
    logic [N-1:0]   y = '0;
    logic           eoc;
    logic [2*N-1:0] p;

    int             n_chk = 0;
    int             n_fail = 0;
    logic [2*N-1:0] sb[$];
    vec_t           vecs[8];

    always #5 clock = ~clock;

    mul_seq_nat #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .x      (x),
        .y      (y),
        .soc    (soc),
        .eoc    (eoc),
        .p      (p)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: normal; 1: keep soc high afterwards; 2: scramble operands and soc while busy
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] e, input int mode);
        int busy;
        busy = 0;
        soc = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        x = a;
        y = b;
        soc = 1'b1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (mode != 1) soc = 1'b0;
        while (eoc === 1'b0 && busy < 20) begin
            busy++;
            if (mode == 2) begin
                x = 8'($urandom);
                y = 8'($urandom);
                soc = ~soc;
            end
            @(posedge clock);
            #1;
        end
        chk("latency", busy, 4);
        chk("product", 32'(p), 32'(sb.pop_front()));
        if (mode == 2) soc = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] a, b;
        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd200, 8'd3,   16'h0258};
        vecs[4] = '{8'd1,   8'd1,   16'h0001};
        vecs[5] = '{8'd255, 8'd1,   16'h00FF};
        vecs[6] = '{8'd128, 8'd2,   16'h0100};
        vecs[7] = '{8'd170, 8'd85,  16'h3872};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_eoc", 32'(eoc), 1);
        chk("reset_p", 32'(p), 0);
        @(negedge clock);
        reset_ = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].x, vecs[i].y, vecs[i].e, 0);

        run_op(8'd3, 8'd5, 16'd15, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("hold_eoc", 32'(eoc), 1);
            chk("hold_p", 32'(p), 15);
        end
        run_op(8'd6, 8'd7, 16'd42, 0);

        run_op(8'd13, 8'd11, 16'h008F, 2);

        soc = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        x = 8'd100;
        y = 8'd100;
        soc = 1'b1;
        @(posedge clock);
        #1;
        soc = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        chk("busy_before_reset", 32'(eoc), 0);
        reset_ = 1'b0;
        #1;
        chk("abort_eoc", 32'(eoc), 1);
        chk("abort_p", 32'(p), 0);
        @(negedge clock);
        reset_ = 1'b1;
        run_op(8'd7, 8'd9, 16'h003F, 0);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, 16'(a) * 16'(b), 0);
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
